// File: rtl/gpio_pad_conditioner.sv
// gpio_pad_conditioner
//   Per-pin GPIO pad conditioner that sits between the IO buffer primitives
//   and the GPIO register block.
//   Inbound path:  2-flop synchronizer -> optional debounce -> edge detect
//                  -> masked interrupt-pending latch.
//   Outbound path: registered drive value and tristate control, with
//                  push-pull or open-drain behaviour per pin.
//
//   Build option: define GPIO_PAD_DEBOUNCE_EN to include the per-pin debounce
//   counters. Without it, value follows the synchronizer directly and the
//   DEBOUNCE parameter has no effect.
//
// Parameters
//   WIDTH     number of pins
//   DEBOUNCE  consecutive stable synchronized samples needed to accept a new
//             level (1..65535)
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   pad_in       raw pad level (asynchronous to clk)
//   pad_out      drive level to buffer I
//   pad_oe_n     tristate control to buffer T (1 = high-Z)
//   out_value    requested drive level
//   out_enable   1 = pin is an output
//   open_drain   1 = open-drain mode
//   value        conditioned input level
//   rise, fall   one-cycle edge pulses on value
//   mask_rise    1 = rising edge sets pending
//   mask_fall    1 = falling edge sets pending
//   irq_clear    write-1-to-clear pending
//   irq_pending  latched edge events
//   irq          OR of irq_pending
module gpio_pad_conditioner #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe_n,
  input  logic [WIDTH-1:0] out_value,
  input  logic [WIDTH-1:0] out_enable,
  input  logic [WIDTH-1:0] open_drain,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  input  logic [WIDTH-1:0] mask_rise,
  input  logic [WIDTH-1:0] mask_fall,
  input  logic [WIDTH-1:0] irq_clear,
  output logic [WIDTH-1:0] irq_pending,
  output logic             irq
);

  logic [WIDTH-1:0] s1_p0;
  logic [WIDTH-1:0] s2_p1;
  logic [WIDTH-1:0] value_nxt;

  // Stage p0/p1: two-flop synchronizer; pad_in is used nowhere else
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_p0 <= '0;
      s2_p1 <= '0;
    end else begin
      s1_p0 <= pad_in;
      s2_p1 <= s1_p0;
    end
  end

`ifdef GPIO_PAD_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt_p2 [WIDTH];

  // Stage p2: count consecutive samples that disagree with value. Any
  // agreeing sample restarts the count, so short glitches never land.
  // The count is cleared when it reaches CNT_LAST, so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2_p1[i] == value[i])       cnt_p2[i] <= '0;
        else if (cnt_p2[i] == CNT_LAST) cnt_p2[i] <= '0;
        else                            cnt_p2[i] <= cnt_p2[i] + 1'b1;
      end
    end
  end

  always_comb begin
    value_nxt = value;
    for (int i = 0; i < WIDTH; i++) begin
      if ((s2_p1[i] != value[i]) && (cnt_p2[i] == CNT_LAST)) value_nxt[i] = s2_p1[i];
    end
  end
`else
  // DEBOUNCE has no effect in this build; value tracks the synchronizer.
  localparam int unused_debounce = DEBOUNCE;

  always_comb begin
    value_nxt = s2_p1;
  end
`endif

  // Stage p2: conditioned level and edge pulses, registered together so
  // rise/fall are high on exactly the cycle value shows the new level
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      value <= value_nxt;
      rise  <= value_nxt & ~value;
      fall  <= ~value_nxt & value;
    end
  end

  // Stage p3: pending latch; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_pending <= '0;
    end else begin
      irq_pending <= (irq_pending & ~irq_clear) | (rise & mask_rise) | (fall & mask_fall);
    end
  end

  assign irq = |irq_pending;

  // Output stage: open-drain pins never drive high; they enable the driver
  // only to pull low and release to high-Z otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      pad_out  <= '0;
      pad_oe_n <= '1;
    end else begin
      pad_out  <= out_value & ~open_drain;
      pad_oe_n <= ~(out_enable & (~open_drain | ~out_value));
    end
  end

endmodule

// File: tb/tb_gpio_pad_conditioner.sv
// tb_gpio_pad_conditioner
//   Self-checking bench for gpio_pad_conditioner. A behavioural model tracks
//   the expected outputs every cycle; directed sequences pin the timing with
//   literal expectations, then a randomized phase exercises all pins.
module tb_gpio_pad_conditioner;
  localparam int W = 8;
  localparam int D = 16;
`ifdef GPIO_PAD_DEBOUNCE_EN
  localparam int LAT = D;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         reset;
  logic [W-1:0] pad_in, pad_out, pad_oe_n;
  logic [W-1:0] out_value, out_enable, open_drain;
  logic [W-1:0] value, rise, fall;
  logic [W-1:0] mask_rise, mask_fall, irq_clear, irq_pending;
  logic         irq;

  int errors = 0;
  int checks = 0;

  gpio_pad_conditioner #(.WIDTH(W), .DEBOUNCE(D)) dut (
    .clk(clk), .reset(reset),
    .pad_in(pad_in), .pad_out(pad_out), .pad_oe_n(pad_oe_n),
    .out_value(out_value), .out_enable(out_enable), .open_drain(open_drain),
    .value(value), .rise(rise), .fall(fall),
    .mask_rise(mask_rise), .mask_fall(mask_fall), .irq_clear(irq_clear),
    .irq_pending(irq_pending), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model. A pin's value flips when the last LAT synchronized
  // samples all disagree with it; the synchronizer is a two-sample delay.
  logic [W-1:0] m_s1, m_s2, m_value, m_rise, m_fall, m_pend, m_pad_out, m_oe_n;
  logic [W-1:0] hist[$];
  bit           m_ok = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] acc;
    logic [W-1:0] nv;
    if (reset) begin
      hist.delete();
      for (int i = 0; i < LAT; i++) hist.push_back('0);
      m_s1 = '0; m_s2 = '0; m_value = '0; m_rise = '0; m_fall = '0;
      m_pend = '0; m_pad_out = '0; m_oe_n = '1;
      m_ok = 1'b1;
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > LAT) void'(hist.pop_front());
      acc = '1;
      foreach (hist[j]) acc &= hist[j] ^ m_value;
      nv = m_value ^ acc;
      m_pend  = (m_pend & ~irq_clear) | (m_rise & mask_rise) | (m_fall & mask_fall);
      m_rise  = nv & ~m_value;
      m_fall  = m_value & ~nv;
      m_value = nv;
      m_s2 = m_s1;
      m_s1 = pad_in;
      for (int i = 0; i < W; i++) begin
        if (open_drain[i]) begin
          m_pad_out[i] = 1'b0;
          m_oe_n[i]    = !(out_enable[i] && !out_value[i]);
        end else begin
          m_pad_out[i] = out_value[i];
          m_oe_n[i]    = !out_enable[i];
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_ok) begin
      chk("model_pad_out", pad_out, m_pad_out);
      chk("model_pad_oe_n", pad_oe_n, m_oe_n);
      chk("model_value", value, m_value);
      chk("model_rise", rise, m_rise);
      chk("model_fall", fall, m_fall);
      chk("model_irq_pending", irq_pending, m_pend);
      chk("model_irq", irq, |m_pend);
    end
  end

  initial begin
    bit found;
    reset = 1'b1; pad_in = '1;
    out_value = '0; out_enable = '0; open_drain = '0;
    mask_rise = '0; mask_fall = '0; irq_clear = '0;

    // Reset held 3 cycles with all pads high
    @(negedge clk);
    chk("reset_oe_n", pad_oe_n, 8'hFF);
    chk("reset_value", value, 8'h00);
    chk("reset_irq", irq, 0);
    wait_edges(2);
    reset = 1'b0;
    wait_edges(LAT + 1);
    chk("rst_rise_early", rise, 8'h00);
    wait_edges(1);
    chk("rst_rise_edge", rise, 8'hFF);
    chk("rst_value", value, 8'hFF);
    wait_edges(1);
    chk("rst_rise_once", rise, 8'h00);
    pad_in = '0;
    wait_edges(2 * LAT + 4);

    // Glitch one sample too short is rejected
    pad_in[0] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    pad_in[0] = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      chk("glitch_value0", value[0], 0);
      chk("glitch_rise0", rise[0], 0);
    end

    // Pulse exactly LAT samples long is accepted
    pad_in[0] = 1'b1;
    wait_edges(LAT);
    pad_in[0] = 1'b0;
    wait_edges(1);
    chk("hold_rise0_early", rise[0], 0);
    wait_edges(1);
    chk("hold_rise0", rise[0], 1);
    wait_edges(LAT);
    chk("hold_fall0", fall[0], 1);
    chk("hold_value0", value[0], 0);
    wait_edges(LAT + 4);

    // Interrupt on pin 3: fall only
    mask_fall = 8'h08; mask_rise = 8'h00;
    pad_in[3] = 1'b1;
    wait_edges(2 * LAT + 4);
    chk("irq_rise_masked", irq_pending, 8'h00);
    chk("irq_rise_masked_irq", irq, 0);
    pad_in[3] = 1'b0;
    wait_edges(LAT + 2);
    chk("irq_fall3", fall[3], 1);
    chk("irq_pend_before", irq_pending, 8'h00);
    wait_edges(1);
    chk("irq_pend_set", irq_pending, 8'h08);
    chk("irq_out_set", irq, 1);
    irq_clear = 8'h08;
    wait_edges(1);
    irq_clear = 8'h00;
    chk("irq_cleared", irq_pending, 8'h00);
    chk("irq_out_cleared", irq, 0);
    pad_in[3] = 1'b1;
    wait_edges(2 * LAT + 4);
    pad_in[3] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3 * LAT + 10; i++) begin
      @(negedge clk);
      if (fall[3]) begin
        found = 1'b1;
        break;
      end
    end
    chk("irq_fall3_seen", found, 1);
    irq_clear = 8'h08;
    wait_edges(1);
    irq_clear = 8'h00;
    chk("irq_set_wins", irq_pending, 8'h08);
    irq_clear = 8'h08;
    wait_edges(1);
    irq_clear = 8'h00;
    mask_fall = 8'h00;

    // Open-drain then push-pull on pin 5
    open_drain = 8'h20; out_enable = 8'h20;
    for (int i = 0; i < 4; i++) begin
      out_value[5] = ~out_value[5];
      @(negedge clk);
      chk("od_pad_out5", pad_out[5], 0);
      chk("od_oe_n5", pad_oe_n[5], out_value[5]);
    end
    open_drain = 8'h00;
    for (int i = 0; i < 4; i++) begin
      out_value[5] = ~out_value[5];
      @(negedge clk);
      chk("pp_pad_out5", pad_out[5], out_value[5]);
      chk("pp_oe_n5", pad_oe_n[5], 0);
    end
    out_enable = '0; out_value = '0;

    // Reset in the middle of a count
    pad_in[2] = 1'b1;
    wait_edges(10);
    reset = 1'b1;
    wait_edges(1);
    chk("midrst_value", value, 8'h00);
    reset = 1'b0;
    wait_edges(LAT + 1);
    chk("midrst_value2_early", value[2], 0);
    wait_edges(1);
    chk("midrst_value2", value[2], 1);
    chk("midrst_rise2", rise[2], 1);
    pad_in = '0;
    wait_edges(2 * LAT + 4);

    // Randomized traffic on all pins
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int p = 0; p < W; p++)
        if ($urandom_range(0, 11) == 0) pad_in[p] = ~pad_in[p];
      if ((c % 64) == 0) begin
        mask_rise = 8'($urandom);
        mask_fall = 8'($urandom);
      end
      irq_clear  = 8'($urandom & $urandom & $urandom);
      out_value  = 8'($urandom);
      out_enable = 8'($urandom);
      open_drain = 8'($urandom);
      reset      = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_edges(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
